// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared definitions for the raster timing generator:
//   - timing_t     : one display mode's geometry (active, porches, sync widths)
//   - VGA_640X480  : 640x480@60 mode, the generator's default geometry
//   - VGA_800X600  : 800x600@60 mode
//   - htot / vtot  : total line / frame length of a mode
//   - clog2        : ceiling log2, used for elaboration-time width checks
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  typedef struct packed {
    int hen;  // active pixels per line
    int hfp;  // horizontal front porch
    int hsw;  // hsync width
    int hbp;  // horizontal back porch
    int ven;  // active lines
    int vfp;  // vertical front porch
    int vsw;  // vsync width
    int vbp;  // vertical back porch
  } timing_t;

  localparam timing_t VGA_640X480 = '{
    hen: 640, hfp: 16, hsw: 96,  hbp: 48,
    ven: 480, vfp: 10, vsw: 2,   vbp: 33
  };

  localparam timing_t VGA_800X600 = '{
    hen: 800, hfp: 40, hsw: 128, hbp: 88,
    ven: 600, vfp: 1,  vsw: 4,   vbp: 23
  };

  function automatic int htot(input timing_t t);
    return t.hen + t.hfp + t.hsw + t.hbp;
  endfunction

  function automatic int vtot(input timing_t t);
    return t.ven + t.vfp + t.vsw + t.vbp;
  endfunction

  // Smallest r with 2**r >= n; a counter holding 0..n-1 needs clog2(n) bits.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//
// Bundle between the timing generator and its consumer (framebuffer reader and
// VGA pin drivers).
//   en           consumer -> generator  advance raster; 0 freezes it
//   hs, vs       generator -> consumer  sync outputs, polarity already applied
//   de           generator -> consumer  display enable
//   x, y         generator -> consumer  clamped pixel / line coordinate
//   line_start   generator -> consumer  one-cycle pulse at the start of a line
//   frame_start  generator -> consumer  one-cycle pulse at the start of a frame
//   fetch_en     generator -> consumer  look-ahead display enable
//   fetch_x/y    generator -> consumer  look-ahead coordinates
// Modports: master = generator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 9
);

  logic          en;
  logic          hs;
  logic          vs;
  logic          de;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          fetch_en;
  logic [XW-1:0] fetch_x;
  logic [YW-1:0] fetch_y;

  modport master (
    input  en,
    output hs, vs, de, x, y, line_start, frame_start,
           fetch_en, fetch_x, fetch_y
  );

  modport slave (
    output en,
    input  hs, vs, de, x, y, line_start, frame_start,
           fetch_en, fetch_x, fetch_y
  );

endinterface

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
//
// Two-dimensional raster position counter. h counts 0..HTOT-1 and wraps; v
// advances once per h wrap and itself wraps at VTOT-1. Asynchronous reset
// loads the start position (H0, V0), which lets the same block serve as the
// main raster and as a look-ahead raster offset by a fixed number of pixels.
//
// Ports:
//   pclk   in   pixel clock
//   rst    in   asynchronous, active-high reset (loads H0, V0)
//   en     in   advance one position when high; hold when low
//   h      out  horizontal position (registered)
//   v      out  vertical position (registered)
//   hwrap  out  high while h sits on its last position (HTOT-1)
// -----------------------------------------------------------------------------
module raster_counter #(
  parameter int CW   = 10,
  parameter int HTOT = 800,
  parameter int VTOT = 525,
  parameter int H0   = 0,
  parameter int V0   = 0
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] h,
  output logic [CW-1:0] v,
  output logic          hwrap
);

  if (H0 < 0 || H0 >= HTOT || V0 < 0 || V0 >= VTOT) begin : g_bad_start
    $error("raster_counter: start position outside the raster");
  end

  localparam logic [CW-1:0] H_LAST = CW'(HTOT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VTOT - 1);
  localparam logic [CW-1:0] H_INIT = CW'(H0);
  localparam logic [CW-1:0] V_INIT = CW'(V0);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;

  assign hwrap = (h_q == H_LAST);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no branch can
    // leave it unassigned and no latch is inferred.
    h_d = h_q;
    v_d = v_q;
    if (en) begin
      if (hwrap) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use <= so each flop samples pre-edge values no matter
  // how the statements are ordered.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      h_q <= H_INIT;
      v_q <= V_INIT;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h = h_q;
  assign v = v_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator. A main raster counter drives the
// display decode (hs, vs, de, x, y, line/frame pulses); a second counter runs
// LEAD pixels ahead and drives an identical decode for the framebuffer fetch,
// so a read with LEAD cycles of latency lines up with de. Every output is
// registered: the value after edge t+1 reflects the counter state at edge t.
//
// Ports:
//   pclk  in   pixel clock
//   rst   in   asynchronous, active-high reset
//   vif   master side of vga_timing_gen_if (en in; sync, enables,
//         coordinates and pulses out)
//
// Geometry defaults to 640x480@60. HS_POL / VS_POL give the active level of
// the sync pulses. CW must hold max(HTOT, VTOT) positions; LEAD is 0..HTOT-1.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int HEN    = VGA_640X480.hen,
  parameter int HFP    = VGA_640X480.hfp,
  parameter int HSW    = VGA_640X480.hsw,
  parameter int HBP    = VGA_640X480.hbp,
  parameter int VEN    = VGA_640X480.ven,
  parameter int VFP    = VGA_640X480.vfp,
  parameter int VSW    = VGA_640X480.vsw,
  parameter int VBP    = VGA_640X480.vbp,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int LEAD   = 2,
  parameter int CW     = 10,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic             pclk,
  input  logic             rst,
  vga_timing_gen_if.master vif
);

  localparam int HTOT = HEN + HFP + HSW + HBP;
  localparam int VTOT = VEN + VFP + VSW + VBP;

  if (clog2(HTOT) > CW || clog2(VTOT) > CW) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for the raster");
  end
  if (clog2(HEN) > XW || clog2(VEN) > YW) begin : g_bad_xy
    $error("vga_timing_gen: XW/YW too narrow for the active area");
  end
  if (LEAD < 0 || LEAD >= HTOT) begin : g_bad_lead
    $error("vga_timing_gen: LEAD must lie in 0..HTOT-1");
  end

  // Region boundaries as counter-width constants so the compares stay
  // width-matched.
  localparam logic [CW-1:0] H_ACT   = CW'(HEN);
  localparam logic [CW-1:0] H_SYNC0 = CW'(HEN + HFP);
  localparam logic [CW-1:0] H_SYNC1 = CW'(HEN + HFP + HSW);
  localparam logic [CW-1:0] V_ACT   = CW'(VEN);
  localparam logic [CW-1:0] V_SYNC0 = CW'(VEN + VFP);
  localparam logic [CW-1:0] V_SYNC1 = CW'(VEN + VFP + VSW);
  localparam logic [XW-1:0] X_MAX   = XW'(HEN - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(VEN - 1);

  logic en;
  assign en = vif.en;

  // ---------------------------------------------------------------------------
  // Raster counters: main at (0,0), look-ahead LEAD raster positions ahead.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] hcnt, vcnt;
  logic [CW-1:0] lh, lv;
  logic          main_hwrap, look_hwrap;

  raster_counter #(
    .CW   (CW),
    .HTOT (HTOT),
    .VTOT (VTOT),
    .H0   (0),
    .V0   (0)
  ) u_main (
    .pclk  (pclk),
    .rst   (rst),
    .en    (en),
    .h     (hcnt),
    .v     (vcnt),
    .hwrap (main_hwrap)
  );

  raster_counter #(
    .CW   (CW),
    .HTOT (HTOT),
    .VTOT (VTOT),
    .H0   (LEAD % HTOT),
    .V0   (LEAD / HTOT)
  ) u_look (
    .pclk  (pclk),
    .rst   (rst),
    .en    (en),
    .h     (lh),
    .v     (lv),
    .hwrap (look_hwrap)
  );

  // The wrap strobes serve consumers of the counter; the decode below works
  // directly from the positions.
  logic unused_hwrap;
  assign unused_hwrap = main_hwrap ^ look_hwrap;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic          hs_d, vs_d, de_d, ls_d, fs_d, fen_d;
  logic [XW-1:0] x_d, fx_d;
  logic [YW-1:0] y_d, fy_d;

  always_comb begin
    de_d  = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs_d  = ((hcnt >= H_SYNC0) && (hcnt < H_SYNC1)) ? HS_POL : ~HS_POL;
    vs_d  = ((vcnt >= V_SYNC0) && (vcnt < V_SYNC1)) ? VS_POL : ~VS_POL;
    // Coordinates clamp at the last active pixel/line through blanking.
    x_d   = (hcnt < H_ACT) ? XW'(hcnt) : X_MAX;
    y_d   = (vcnt < V_ACT) ? YW'(vcnt) : Y_MAX;
    // Pulses are gated by en so a frozen raster cannot repeat or stretch them.
    ls_d  = en && (hcnt == '0);
    fs_d  = en && (hcnt == '0) && (vcnt == '0);
    fen_d = (lh < H_ACT) && (lv < V_ACT);
    fx_d  = (lh < H_ACT) ? XW'(lh) : X_MAX;
    fy_d  = (lv < V_ACT) ? YW'(lv) : Y_MAX;
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic          hs_q, vs_q, de_q, ls_q, fs_q, fen_q;
  logic [XW-1:0] x_q, fx_q;
  logic [YW-1:0] y_q, fy_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      fen_q <= 1'b0;
      fx_q  <= '0;
      fy_q  <= '0;
    end else begin
      ls_q <= ls_d;
      fs_q <= fs_d;
      if (en) begin
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        de_q  <= de_d;
        x_q   <= x_d;
        y_q   <= y_d;
        fen_q <= fen_d;
        fx_q  <= fx_d;
        fy_q  <= fy_d;
      end
    end
  end

  assign vif.hs          = hs_q;
  assign vif.vs          = vs_q;
  assign vif.de          = de_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.line_start  = ls_q;
  assign vif.frame_start = fs_q;
  assign vif.fetch_en    = fen_q;
  assign vif.fetch_x     = fx_q;
  assign vif.fetch_y     = fy_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two generators share one pixel clock:
//   u_dut_a  default 640x480 geometry, LEAD=2 (line-level behaviour, freeze)
//   u_dut_b  small 16x12 raster, LEAD=3, active-high hsync (frame wraps,
//            look-ahead across line/frame wrap, mid-frame reset)
// Expected values come from a raster-index model: after the first enabled edge
// following reset, output cycle n reflects raster index n and the fetch
// outputs reflect index n+LEAD.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic        fen;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] fx;
    logic [15:0] fy;
  } obs_t;

  localparam timing_t G_A = VGA_640X480;
  localparam timing_t G_B = '{hen: 10, hfp: 2, hsw: 3, hbp: 1,
                              ven: 6,  vfp: 1, vsw: 2, vbp: 3};
  localparam int LEAD_A = 2;
  localparam int LEAD_B = 3;

  logic pclk  = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 pclk = ~pclk;

  vga_timing_gen_if #(.XW(10), .YW(9)) vif_a ();
  vga_timing_gen_if #(.XW(4),  .YW(3)) vif_b ();

  vga_timing_gen u_dut_a (
    .pclk (pclk),
    .rst  (rst_a),
    .vif  (vif_a)
  );

  vga_timing_gen #(
    .HEN(10), .HFP(2), .HSW(3), .HBP(1),
    .VEN(6),  .VFP(1), .VSW(2), .VBP(3),
    .HS_POL(1'b1), .VS_POL(1'b0),
    .LEAD(3), .CW(5), .XW(4), .YW(3)
  ) u_dut_b (
    .pclk (pclk),
    .rst  (rst_b),
    .vif  (vif_b)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic obs_t model(input int n, input int lead, input timing_t g,
                                 input bit hpol, input bit vpol);
    obs_t o;
    int ht, vt, h, v, fh, fv;
    ht = g.hen + g.hfp + g.hsw + g.hbp;
    vt = g.ven + g.vfp + g.vsw + g.vbp;
    h  = n % ht;
    v  = (n / ht) % vt;
    fh = (n + lead) % ht;
    fv = ((n + lead) / ht) % vt;
    o.de  = (h < g.hen) && (v < g.ven);
    o.hs  = (h >= g.hen + g.hfp && h < g.hen + g.hfp + g.hsw) ? hpol : ~hpol;
    o.vs  = (v >= g.ven + g.vfp && v < g.ven + g.vfp + g.vsw) ? vpol : ~vpol;
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    o.x   = 16'((h < g.hen) ? h : g.hen - 1);
    o.y   = 16'((v < g.ven) ? v : g.ven - 1);
    o.fen = (fh < g.hen) && (fv < g.ven);
    o.fx  = 16'((fh < g.hen) ? fh : g.hen - 1);
    o.fy  = 16'((fv < g.ven) ? fv : g.ven - 1);
    return o;
  endfunction

  function automatic obs_t exp_a(input int n);
    return model(n, LEAD_A, G_A, 1'b0, 1'b0);
  endfunction

  function automatic obs_t exp_b(input int n);
    return model(n, LEAD_B, G_B, 1'b1, 1'b0);
  endfunction

  // Levels of index n held by a frozen generator: pulses forced low.
  function automatic obs_t held(input obs_t o);
    obs_t r;
    r    = o;
    r.ls = 1'b0;
    r.fs = 1'b0;
    return r;
  endfunction

  function automatic obs_t rst_obs(input bit hpol, input bit vpol);
    obs_t r;
    r    = '0;
    r.hs = ~hpol;
    r.vs = ~vpol;
    return r;
  endfunction

  function automatic obs_t sample_a();
    obs_t o;
    o.de  = vif_a.de;
    o.hs  = vif_a.hs;
    o.vs  = vif_a.vs;
    o.ls  = vif_a.line_start;
    o.fs  = vif_a.frame_start;
    o.fen = vif_a.fetch_en;
    o.x   = 16'(vif_a.x);
    o.y   = 16'(vif_a.y);
    o.fx  = 16'(vif_a.fetch_x);
    o.fy  = 16'(vif_a.fetch_y);
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o.de  = vif_b.de;
    o.hs  = vif_b.hs;
    o.vs  = vif_b.vs;
    o.ls  = vif_b.line_start;
    o.fs  = vif_b.frame_start;
    o.fen = vif_b.fetch_en;
    o.x   = 16'(vif_b.x);
    o.y   = 16'(vif_b.y);
    o.fx  = 16'(vif_b.fetch_x);
    o.fy  = 16'(vif_b.fetch_y);
    return o;
  endfunction

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    obs_t got, exp;
    vif_a.en = 1'b1;
    vif_b.en = 1'b1;
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    repeat (3) tick();
    got = sample_a(); exp = rst_obs(1'b0, 1'b0); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL reset_a got=%p exp=%p", got, exp);
    end
    got = sample_b(); exp = rst_obs(1'b1, 1'b0); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL reset_b got=%p exp=%p", got, exp);
    end
  endtask

  task automatic test_first_edge_a();
    obs_t got, exp;
    rst_a = 1'b0;
    tick();
    got = sample_a(); exp = exp_a(0); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL first_edge_a got=%p exp=%p", got, exp);
    end
  endtask

  task automatic test_line0_a();
    obs_t got, exp;
    int hs_first, hs_last;
    hs_first = -1;
    hs_last  = -1;
    for (int i = 1; i <= 801; i++) begin
      tick();
      got = sample_a(); exp = exp_a(i); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL line0_a n=%0d got=%p exp=%p", i, got, exp);
      end
      if (i < 800 && got.hs == 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (i == 799) begin
        tests_run++;
        if (got.x !== 16'd639) begin
          tests_failed++;
          $display("FAIL x_clamp_a got=%0d exp=639", got.x);
        end
      end
    end
    tests_run++;
    if (hs_first != 656 || hs_last != 751) begin
      tests_failed++;
      $display("FAIL hs_window_a got=%0d..%0d exp=656..751", hs_first, hs_last);
    end
  endtask

  task automatic test_freeze_a();
    obs_t got, exp;
    int ls_cnt;
    for (int i = 802; i <= 1599; i++) begin
      tick();
      got = sample_a(); exp = exp_a(i); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL run_a n=%0d got=%p exp=%p", i, got, exp);
      end
    end
    // Freeze with the raster parked just before the line wrap.
    vif_a.en = 1'b0;
    ls_cnt   = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      got = sample_a(); exp = held(exp_a(1599)); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL freeze_a k=%0d got=%p exp=%p", k, got, exp);
      end
      if (got.ls) ls_cnt++;
    end
    tests_run++;
    if (ls_cnt != 0) begin
      tests_failed++;
      $display("FAIL freeze_ls_a got=%0d exp=0", ls_cnt);
    end
    // Resume: one enabled edge produces the line_start, then freeze again to
    // confirm the pulse is not stretched.
    vif_a.en = 1'b1;
    tick();
    got = sample_a(); exp = exp_a(1600); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL resume_a got=%p exp=%p", got, exp);
    end
    ls_cnt = got.ls ? 1 : 0;
    vif_a.en = 1'b0;
    tick();
    got = sample_a(); exp = held(exp_a(1600)); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL no_stretch_a got=%p exp=%p", got, exp);
    end
    if (got.ls) ls_cnt++;
    vif_a.en = 1'b1;
    for (int i = 1601; i <= 1615; i++) begin
      tick();
      got = sample_a(); exp = exp_a(i); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL after_resume_a n=%0d got=%p exp=%p", i, got, exp);
      end
      if (got.ls) ls_cnt++;
    end
    tests_run++;
    if (ls_cnt != 1) begin
      tests_failed++;
      $display("FAIL resume_ls_count_a got=%0d exp=1", ls_cnt);
    end
  endtask

  // Two full frames plus a few cycles on the small raster (frame = 192).
  task automatic test_lead_b();
    obs_t got, exp;
    int fs_cnt, fs_last;
    fs_cnt  = 0;
    fs_last = -1;
    rst_b   = 1'b0;
    for (int i = 0; i <= 387; i++) begin
      tick();
      got = sample_b(); exp = exp_b(i); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL lead_b n=%0d got=%p exp=%p", i, got, exp);
      end
      if (got.fs) begin
        fs_cnt++;
        fs_last = i;
      end
    end
    tests_run++;
    if (fs_cnt != 3 || fs_last != 384) begin
      tests_failed++;
      $display("FAIL frame_period_b got=%0d pulses last=%0d exp=3 last=384",
               fs_cnt, fs_last);
    end
  endtask

  task automatic test_reset_mid_b();
    obs_t got, exp;
    for (int i = 388; i <= 455; i++) begin
      tick();
      got = sample_b(); exp = exp_b(i); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL pre_reset_b n=%0d got=%p exp=%p", i, got, exp);
      end
    end
    // Mid-frame (line 4, pixel 7): reset must act without a clock edge.
    rst_b = 1'b1;
    #1;
    got = sample_b(); exp = rst_obs(1'b1, 1'b0); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL async_reset_b got=%p exp=%p", got, exp);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      got = sample_b(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL reset_hold_b k=%0d got=%p exp=%p", k, got, exp);
      end
    end
    rst_b = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      tick();
      got = sample_b(); exp = exp_b(i); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL restart_b n=%0d got=%p exp=%p", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_edge_a();
    test_line0_a();
    test_freeze_a();
    test_lead_b();
    test_reset_mid_b();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "timeout");
  end

endmodule
